uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Parametrised next-generation UART receiver. Adds a 2-flop input synchroniser, N-times oversampling with 3-sample majority vote, and an optional parity bit.
- Supports 1 or 2 stop bits and contains an internal first-word-fall-through (FWFT) receive FIFO.
- Sits between the board rxd pin and the CPU MMIO/UART layer. Presents received bytes on an AXI4-Stream-style valid/ready output.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..9).
- CLOCK_FREQ, 50_000_000, clk frequency in Hz.
- BAUD_RATE, 115200, line rate in baud.
- OVERSAMPLE, 16, sample ticks per bit; even, >= 8.
- STOP_BITS, 1, stop bits checked (1 or 2).
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.
- FIFO_DEPTH, 8, receive FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rxd  in  1  asynchronous serial input; idle high.
- m_axis_tdata  out  DATA_WIDTH  FIFO head word.
- m_axis_tvalid  out  1  FIFO non-empty.
- m_axis_tready  in  1  consumer accepts head word.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  frame reception in progress (state != IDLE).
- overrun_error  out  1  1-cycle pulse: good frame dropped because FIFO was full.
- frame_error  out  1  1-cycle pulse: a stop bit sampled 0.
- parity_error  out  1  1-cycle pulse: parity mismatch; tied 0 when parity is compiled out.

Behaviour:
- Reset values:
  - Synchroniser flops = 1; state = IDLE.
  - All counters = 0; FIFO empty.
  - m_axis_tvalid = 0, m_axis_tdata = 0, fifo_count = 0.
  - busy and all error outputs = 0.
- Reset mid-frame aborts the frame and empties the FIFO.
- Synchroniser: rxd passes through two flops; only the synchronised value (rxs) is used. Pin-to-decision latency is 2 clocks.
- Tick generator:
  - DIV = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE), integer floor; elaboration error if DIV < 1.
  - Prescale counter emits a 1-clk tick every DIV clocks.
  - Prescale counter and sample counter (scnt, 0..OVERSAMPLE-1) are cleared on start detection.
- State IDLE:
  - A falling edge of rxs (previous 1, current 0) -> state START, scnt = 0.
- Bit sampling (all bit states):
  - rxs is captured on ticks at scnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - Bit value = majority of the 3 samples, decided on the scnt = OVERSAMPLE/2+1 tick.
  - Bit period ends on the tick at scnt = OVERSAMPLE-1; scnt then wraps to 0.
- State START:
  - Majority 1 -> false start: return to IDLE, no error pulse.
  - Majority 0 -> at end of bit go to DATA, bit index = 0.
- State DATA:
  - LSB first; the bit is shifted into the data shift register at the decision tick.
  - After bit DATA_WIDTH-1 ends -> PARITY if compiled in, else STOP.
- State PARITY: see Optional Feature.
- State STOP:
  - Each stop bit is decided by majority.
  - A 0 sets a sticky frame-fail flag.
  - Non-final stop bit: wait for end of bit.
  - Final stop bit: act on its decision tick, without waiting for end of bit, so the next start edge is caught early. On that tick:
    - Any failure (frame or parity) -> pulse frame_error and/or parity_error, discard word.
    - Otherwise push word to FIFO.
    - State -> IDLE.
- FIFO:
  - FWFT: m_axis_tvalid = (fifo_count != 0); m_axis_tdata = head entry.
  - Pop when m_axis_tvalid && m_axis_tready.
  - A pushed word is visible on m_axis_tvalid the next clock (latency 1 from the final stop decision tick).
  - Push while full without a same-cycle pop -> word dropped, overrun_error pulses, FIFO contents unchanged.
  - Push and pop in the same cycle while full -> both happen, no overrun, count unchanged.
  - Push and pop in the same cycle while non-empty -> count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Error pulses are exactly 1 clk wide and never sticky.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA.
  - The parity bit is decided by majority.
  - Expected value = XOR of data bits, XOR PARITY_ODD.
  - A mismatch sets a sticky parity-fail flag; parity_error pulses at the final stop decision and the word is discarded.
  - Frame is 1+DATA_WIDTH+1+STOP_BITS bits.
- Undefined:
  - No PARITY state; parity_error is constant 0.
  - PARITY_ODD is ignored.
  - Frame is 1+DATA_WIDTH+STOP_BITS bits.

Test Plan:
- Common setup: CLOCK_FREQ=1_600_000, BAUD_RATE=100_000, OVERSAMPLE=16 (DIV=1, 16 clk/bit), DATA_WIDTH=8, FIFO_DEPTH=4.
- Send 0xA5, 8N1, m_axis_tready=1 -> m_axis_tdata=0xA5 with m_axis_tvalid high for one cycle; no error pulses; busy low after final stop decision.
- 3-clk low glitch on rxd while idle -> false start: no FIFO push, no error pulse, busy returns to 0 within 1 bit time.
- Single-clk inverted spike at a bit centre inside byte 0x3C -> majority vote rejects it; 0x3C received.
- Frame 0x55 with stop bit driven 0 -> frame_error pulses 1 clk; fifo_count stays 0.
- m_axis_tready=0, send 0x01..0x05 -> fifo_count = 4; overrun_error pulses once on 0x05. Then ready=1 pops 0x01, 0x02, 0x03, 0x04 in order.
- With UART_RX_PARITY_EN and PARITY_ODD=0:
  - 0x07 with parity bit 1 -> accepted.
  - 0x07 with parity bit 0 -> parity_error pulse, no push.
  - STOP_BITS=2 with second stop bit 0 -> frame_error pulse.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with a 2-flop input synchroniser,
// 3-sample majority vote per bit, 1 or 2 stop bits and a first-word-fall-through
// receive FIFO presented as an AXI4-Stream-style valid/ready output.
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the data
// bits, sense selected by PARITY_ODD). With the macro undefined there is no
// parity bit and parity_error is tied 0.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          overrun_error,
  output logic                          frame_error,
  output logic                          parity_error
);

  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_WIDTH);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  // sample points around the bit centre, and the last tick of a bit
  localparam logic [SW-1:0] S_PRE = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE/2);
  localparam logic [SW-1:0] S_DEC = SW'(OVERSAMPLE/2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

  // parameter sanity, caught at elaboration
  generate
    if (DIV < 1) begin : g_div_chk
      $error("uart_rx_fifo: CLOCK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
      $error("uart_rx_fifo: OVERSAMPLE must be even and >= 8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
      $error("uart_rx_fifo: STOP_BITS must be 1 or 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_dw_chk
      $error("uart_rx_fifo: DATA_WIDTH must be 5..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fd_chk
      $error("uart_rx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_par_chk
      $error("uart_rx_fifo: PARITY_ODD must be 0 or 1");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic                  sync1, rxs, rxs_d;
  logic [PW-1:0]         pcnt;
  logic                  tick;
  logic [SW-1:0]         scnt;
  logic [1:0]            smp;
  logic                  maj;
  state_t                state;
  logic [BW-1:0]         bidx;
  logic                  sidx;
  logic                  ffail, pfail;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  start_det;
  logic                  at_pre, at_mid, at_dec, at_end;
  logic                  last_stop;
  logic                  push, pop, wr, full;
  logic [AW-1:0]         wptr, rptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  // two-flop synchroniser plus one delay flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  assign start_det = (state == IDLE) && rxs_d && !rxs;
  assign tick      = (pcnt == PW'(DIV - 1));

  // prescaler: one tick every DIV clocks, realigned on every start edge
  always_ff @(posedge clk) begin
    if (rst || start_det || tick) pcnt <= '0;
    else                          pcnt <= pcnt + 1'b1;
  end

  assign at_pre = tick && (scnt == S_PRE);
  assign at_mid = tick && (scnt == S_MID);
  assign at_dec = tick && (scnt == S_DEC);
  assign at_end = tick && (scnt == S_END);

  // first two of the three centre samples; the third is rxs at the decision tick
  always_ff @(posedge clk) begin
    if (rst) begin
      smp <= '0;
    end else begin
      if (at_pre) smp[0] <= rxs;
      if (at_mid) smp[1] <= rxs;
    end
  end

  assign maj = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);

  assign last_stop = (sidx == 1'(STOP_BITS - 1));

  // the final stop bit commits the word on its decision tick so a back-to-back
  // start edge is not missed
  assign push = (state == STOP) && at_dec && last_stop && maj && !ffail && !pfail;

`ifdef UART_RX_PARITY_EN
  logic perr;
  logic par_exp;
  assign par_exp      = (^shreg) ^ PARITY_ODD[0];
  assign parity_error = perr;
`else
  assign parity_error = 1'b0;
`endif

  // receive FSM: bit timing, data shift, stop/parity checks and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      scnt        <= '0;
      bidx        <= '0;
      sidx        <= 1'b0;
      ffail       <= 1'b0;
      pfail       <= 1'b0;
      shreg       <= '0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr        <= 1'b0;
`endif
    end else begin
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr        <= 1'b0;
`endif
      if (state != IDLE && tick) scnt <= at_end ? '0 : scnt + 1'b1;
      case (state)
        IDLE: begin
          if (start_det) begin
            state <= START;
            scnt  <= '0;
            bidx  <= '0;
            sidx  <= 1'b0;
            ffail <= 1'b0;
            pfail <= 1'b0;
          end
        end
        START: begin
          if (at_dec && maj) begin
            state <= IDLE;        // glitch, not a real start bit
          end else if (at_end) begin
            state <= DATA;
            bidx  <= '0;
          end
        end
        DATA: begin
          if (at_dec) shreg <= {maj, shreg[DATA_WIDTH-1:1]};
          if (at_end) begin
            if (bidx == BW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
              sidx  <= 1'b0;
`endif
            end else begin
              bidx <= bidx + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (at_dec && (maj != par_exp)) pfail <= 1'b1;
          if (at_end) begin
            state <= STOP;
            sidx  <= 1'b0;
          end
        end
`endif
        STOP: begin
          if (at_dec) begin
            if (last_stop) begin
              frame_error <= !maj || ffail;
`ifdef UART_RX_PARITY_EN
              perr        <= pfail;
`endif
              state       <= IDLE;
            end else if (!maj) begin
              ffail <= 1'b1;
            end
          end else if (at_end) begin
            sidx <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // FIFO: a push while full only lands if the head leaves in the same cycle
  assign full          = (count == CW'(FIFO_DEPTH));
  assign m_axis_tvalid = (count != '0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign wr            = push && (!full || pop);
  assign m_axis_tdata  = m_axis_tvalid ? mem[rptr] : '0;
  assign fifo_count    = count;

  // storage array, no reset needed: reads are gated by occupancy
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= shreg;
  end

  // pointers, occupancy and the overrun pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      overrun_error <= 1'b0;
    end else begin
      overrun_error <= push && full && !pop;
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frames are bit-banged onto rxd, accepted bytes are
// queued as expectations and popped as the stream output delivers them.
// Define UART_RX_PARITY_EN for both RTL and bench to exercise parity/2 stop bits.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int DW   = 8;
  localparam int FD   = 4;
  localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rxd;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [2:0]    fifo_count;
  logic          busy, overrun_error, frame_error, parity_error;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_WIDTH(DW), .CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000),
    .OVERSAMPLE(16), .STOP_BITS(NSTOP), .PARITY_ODD(PODD), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .fifo_count(fifo_count), .busy(busy),
    .overrun_error(overrun_error), .frame_error(frame_error),
    .parity_error(parity_error)
  );

  int n_cmp = 0, n_err = 0;
  int vld_cyc = 0, fe_cyc = 0, pe_cyc = 0, ov_cyc = 0;
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // monitor: pulse-cycle counters and scoreboard pops on every handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_tvalid) vld_cyc++;
      if (frame_error)   fe_cyc++;
      if (parity_error)  pe_cyc++;
      if (overrun_error) ov_cyc++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) chk("pop_with_nothing_expected", 32'(exp_q.size()), 1);
        else                   chk("rx_data", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // par: -1 = correct parity, 0/1 = forced parity bit (parity builds only)
  // stop_bad: bit s set drives stop bit s low; spike: frame bit index to
  // invert for one clock at its centre (-1 = none)
  task automatic send(input logic [DW-1:0] d, input int par, input logic [1:0] stop_bad,
                      input int spike, input bit expect_ok);
    logic b [$];
    b.push_back(1'b0);
    for (int i = 0; i < DW; i++) b.push_back(d[i]);
`ifdef UART_RX_PARITY_EN
    if (par < 0) b.push_back((^d) ^ PODD[0]);
    else         b.push_back(par[0]);
`endif
    for (int s = 0; s < NSTOP; s++) b.push_back(!stop_bad[s]);
    if (expect_ok) exp_q.push_back(d);
    for (int k = 0; k < b.size(); k++) begin
      rxd = b[k];
      if (k == spike) begin
        cyc(8);
        rxd = ~b[k];
        cyc(1);
        rxd = b[k];
        cyc(7);
      end else begin
        cyc(16);
      end
    end
    rxd = 1'b1;
  endtask

  int v0, f0, p0, o0;

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    m_axis_tready = 1'b0;
    cyc(3);
    @(negedge clk);
    chk("rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_tdata", 32'(m_axis_tdata), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_err", 32'(frame_error), 0);
    chk("rst_overrun", 32'(overrun_error), 0);
    chk("rst_parity_err", 32'(parity_error), 0);
    cyc(1);
    rst = 1'b0;
    cyc(4);

    // plain frame, consumer always ready
    m_axis_tready = 1'b1;
    v0 = vld_cyc;
    send(8'hA5, -1, 2'b00, -1, 1'b1);
    @(negedge clk);
    chk("a5_busy_after", 32'(busy), 0);
    chk("a5_valid_cycles", 32'(vld_cyc - v0), 1);
    chk("a5_q_drained", 32'(exp_q.size()), 0);
    chk("a5_errors", 32'(fe_cyc + pe_cyc + ov_cyc), 0);
    cyc(8);

    // 3-clock low glitch while idle
    rxd = 1'b0;
    cyc(3);
    rxd = 1'b1;
    cyc(2);
    @(negedge clk);
    chk("glitch_busy_seen", 32'(busy), 1);
    cyc(16);
    @(negedge clk);
    chk("glitch_busy_clear", 32'(busy), 0);
    chk("glitch_count", 32'(fifo_count), 0);
    chk("glitch_errors", 32'(fe_cyc + pe_cyc + ov_cyc), 0);
    cyc(8);

    // single-clock spike at the centre of data bit 2 (frame bit 3)
    send(8'h3C, -1, 2'b00, 3, 1'b1);
    cyc(4);
    @(negedge clk);
    chk("spike_q_drained", 32'(exp_q.size()), 0);
    cyc(8);

    // stop bit low
    f0 = fe_cyc;
    send(8'h55, -1, 2'b01, -1, 1'b0);
    cyc(4);
    @(negedge clk);
    chk("stop0_frame_err", 32'(fe_cyc - f0), 1);
    chk("stop0_count", 32'(fifo_count), 0);
    cyc(8);

    // fill with consumer stalled, fifth byte overruns
    m_axis_tready = 1'b0;
    o0 = ov_cyc;
    for (int v = 1; v <= 5; v++) send(DW'(v), -1, 2'b00, -1, v <= FD);
    cyc(4);
    @(negedge clk);
    chk("ovr_count_full", 32'(fifo_count), FD);
    chk("ovr_pulse", 32'(ov_cyc - o0), 1);
    chk("ovr_head_valid", 32'(m_axis_tvalid), 1);
    cyc(1);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("ovr_q_drained", 32'(exp_q.size()), 0);
    cyc(2);
    @(negedge clk);
    chk("ovr_count_empty", 32'(fifo_count), 0);
    cyc(8);

`ifdef UART_RX_PARITY_EN
    p0 = pe_cyc;
    f0 = fe_cyc;
    send(8'h07, 1, 2'b00, -1, 1'b1);
    cyc(4);
    @(negedge clk);
    chk("par_ok_q_drained", 32'(exp_q.size()), 0);
    chk("par_ok_no_err", 32'(pe_cyc - p0), 0);
    send(8'h07, 0, 2'b00, -1, 1'b0);
    cyc(4);
    @(negedge clk);
    chk("par_bad_pulse", 32'(pe_cyc - p0), 1);
    chk("par_bad_count", 32'(fifo_count), 0);
    send(8'h5A, -1, 2'b10, -1, 1'b0);
    cyc(4);
    @(negedge clk);
    chk("stop2_frame_err", 32'(fe_cyc - f0), 1);
    chk("stop2_count", 32'(fifo_count), 0);
    cyc(8);
`endif

    // reset in the middle of a frame with a byte held in the FIFO
    m_axis_tready = 1'b0;
    send(8'h11, -1, 2'b00, -1, 1'b0);
    cyc(2);
    @(negedge clk);
    chk("midrst_count_before", 32'(fifo_count), 1);
    rxd = 1'b0;
    cyc(40);
    @(negedge clk);
    chk("midrst_busy_before", 32'(busy), 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_count", 32'(fifo_count), 0);
    chk("midrst_tvalid", 32'(m_axis_tvalid), 0);
    cyc(20);
    m_axis_tready = 1'b1;
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
